// File: rtl/nmr_pkg.sv
// Shared types and helpers for the registered N-modular-redundancy voter.
package nmr_pkg;

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned STATE_W = 2;
  localparam int unsigned FT_W    = 16;

  typedef enum logic [STATE_W-1:0] {
    NORMAL   = 2'd0,
    DEGRADED = 2'd1,
    FAILSAFE = 2'd2
  } nmr_state_e;

  // Number of set bits; callers zero-extend their N-bit vectors into 32 bits.
  function automatic int unsigned popcount_n(input logic [31:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      cnt = cnt + int'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/nmr_voter_seq_if.sv
// Voter bus: replicated channel data in, voted result and health status out.
// FAULT_TOTAL is present only when NMR_FAULT_LOG_EN is defined.
interface nmr_voter_seq_if #(
  parameter int unsigned N = 5,
  parameter int unsigned W = 1
);
  import nmr_pkg::*;

  logic                valid_in;
  logic [N*W-1:0]      x;
  logic                clr_mask;
  logic [W-1:0]        z;
  logic                valid_out;
  logic [N-1:0]        disagree;
  logic [N-1:0]        mask;
  logic                no_maj;
  logic [STATE_W-1:0]  state;
`ifdef NMR_FAULT_LOG_EN
  logic [FT_W-1:0]     fault_total;
`endif

  modport master (
    output valid_in, x, clr_mask,
    input  z, valid_out, disagree, mask, no_maj, state
`ifdef NMR_FAULT_LOG_EN
    , input fault_total
`endif
  );

  modport slave (
    input  valid_in, x, clr_mask,
    output z, valid_out, disagree, mask, no_maj, state
`ifdef NMR_FAULT_LOG_EN
    , output fault_total
`endif
  );

endinterface

// File: rtl/nmr_bit_majority.sv
// Single-bit majority over the unmasked channels; a tie holds the previous bit.
module nmr_bit_majority
  import nmr_pkg::*;
#(
  parameter int unsigned N = 5
) (
  input  logic [N-1:0] bits_i,
  input  logic [N-1:0] mask_i,
  input  logic         prev_i,
  output logic         vote_c,
  output logic         tie_c
);

  logic [N-1:0] live;
  logic [N-1:0] live_ones;

  assign live      = ~mask_i;
  assign live_ones = bits_i & live;

  always_comb begin
    int unsigned act;
    int unsigned ones;
    int unsigned zeros;
    act    = popcount_n(32'(live));
    ones   = popcount_n(32'(live_ones));
    zeros  = act - ones;
    vote_c = prev_i;
    tie_c  = 1'b0;
    if (2 * ones > act) begin
      vote_c = 1'b1;
    end else if (2 * zeros > act) begin
      vote_c = 1'b0;
    end else begin
      tie_c  = 1'b1;
    end
  end

endmodule

// File: rtl/nmr_voter_seq.sv
// Registered NMR voter with per-channel fault counting, sticky masking and health FSM.
// Define NMR_FAULT_LOG_EN to add the saturating FAULT_TOTAL event counter.
module nmr_voter_seq
  import nmr_pkg::*;
#(
  parameter int unsigned N         = 5,
  parameter int unsigned W         = 1,
  parameter int unsigned FAULT_LIM = 3,
  parameter int unsigned MIN_ACT   = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  nmr_voter_seq_if.slave  bus
);

  logic [W-1:0]     z_q, z_d;
  logic             valid_out_q, valid_out_d;
  logic [N-1:0]     disagree_q, disagree_d;
  logic [N-1:0]     mask_q, mask_d;
  logic             no_maj_q, no_maj_d;
  nmr_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q [N];
  logic [CNT_W-1:0] cnt_d [N];

  logic [W-1:0]     chan [N];
  logic [N-1:0]     chan_bits [W];
  logic [W-1:0]     vote_c;
  logic [W-1:0]     tie_c;
  logic [N-1:0]     unmasked;
  logic [N-1:0]     mask_set;
  logic [N-1:0]     refuse_vec;

  assign unmasked = ~mask_q;

  // Slice the flat bus into channels, then regroup per bit for the voters.
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      chan[i] = bus.x[i*W +: W];
    end
  end

  always_comb begin
    for (int unsigned b = 0; b < W; b++) begin
      for (int unsigned i = 0; i < N; i++) begin
        chan_bits[b][i] = chan[i][b];
      end
    end
  end

  for (genvar b = 0; b < W; b++) begin : g_bit
    nmr_bit_majority #(.N(N)) u_maj (
      .bits_i (chan_bits[b]),
      .mask_i (mask_q),
      .prev_i (z_q[b]),
      .vote_c (vote_c[b]),
      .tie_c  (tie_c[b])
    );
  end

  // Vote capture, fault counters, mask allocation and health FSM.
  always_comb begin
    int unsigned avail;
    z_d         = z_q;
    valid_out_d = bus.valid_in;
    disagree_d  = disagree_q;
    no_maj_d    = no_maj_q;
    mask_d      = mask_q;
    cnt_d       = cnt_q;
    state_d     = state_q;
    mask_set    = '0;
    refuse_vec  = '0;
    avail       = popcount_n(32'(unmasked));

    if (bus.valid_in) begin
      z_d      = vote_c;
      no_maj_d = |tie_c;
      for (int unsigned i = 0; i < N; i++) begin
        disagree_d[i] = !mask_q[i] && (chan[i] != vote_c);
      end
      // Ascending index order decides who gets masked when the budget runs out.
      for (int unsigned i = 0; i < N; i++) begin
        if (!mask_q[i]) begin
          if (disagree_d[i]) begin
            cnt_d[i] = (cnt_q[i] == '1) ? cnt_q[i] : cnt_q[i] + 1'b1;
            if (cnt_d[i] >= CNT_W'(FAULT_LIM)) begin
              if (avail >= MIN_ACT + 1) begin
                mask_set[i] = 1'b1;
                avail       = avail - 1;
              end else begin
                refuse_vec[i] = 1'b1;
                cnt_d[i]      = CNT_W'(FAULT_LIM);
              end
            end
          end else begin
            cnt_d[i] = '0;
          end
        end
      end
      mask_d = mask_q | mask_set;

      if ((|refuse_vec) || no_maj_d) begin
        state_d = FAILSAFE;
      end else begin
        case (state_q)
          NORMAL:   state_d = (mask_d != '0) ? DEGRADED : NORMAL;
          DEGRADED: state_d = DEGRADED;
          FAILSAFE: state_d = (mask_d != '0) ? DEGRADED : NORMAL;
          default:  state_d = NORMAL;
        endcase
      end
    end

    // Clear takes effect after the vote above, overriding any new mask.
    if (bus.clr_mask) begin
      mask_d  = '0;
      cnt_d   = '{default: '0};
      state_d = NORMAL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q         <= '0;
      valid_out_q <= 1'b0;
      disagree_q  <= '0;
      mask_q      <= '0;
      no_maj_q    <= 1'b0;
      state_q     <= NORMAL;
      for (int unsigned i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      z_q         <= z_d;
      valid_out_q <= valid_out_d;
      disagree_q  <= disagree_d;
      mask_q      <= mask_d;
      no_maj_q    <= no_maj_d;
      state_q     <= state_d;
      for (int unsigned i = 0; i < N; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.z         = z_q;
  assign bus.valid_out = valid_out_q;
  assign bus.disagree  = disagree_q;
  assign bus.mask      = mask_q;
  assign bus.no_maj    = no_maj_q;
  assign bus.state     = state_q;

`ifdef NMR_FAULT_LOG_EN
  logic [FT_W-1:0] fault_total_q, fault_total_d;
  logic [FT_W:0]   ft_sum;
  logic [N-1:0]    ft_masks;

  // Masks cancelled by a same-edge clear are not counted as masking events.
  assign ft_masks = bus.clr_mask ? '0 : mask_set;

  always_comb begin
    ft_sum        = (FT_W+1)'(fault_total_q)
                  + (FT_W+1)'(popcount_n(32'(ft_masks)))
                  + (FT_W+1)'(popcount_n(32'(refuse_vec)));
    fault_total_d = ft_sum[FT_W] ? '1 : ft_sum[FT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_total_q <= '0;
    end else begin
      fault_total_q <= fault_total_d;
    end
  end

  assign bus.fault_total = fault_total_q;
`endif

endmodule
